serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB-first, one bit per clock, registered borrow.
// Latency: done_valid rises WIDTH edges after the accepting edge; one operation per WIDTH+2 cycles at best.
// Backpressure: start_ready only in IDLE; the result is held in DONE until done_ready.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_reg;
  logic             borrow_q;
  logic [CW-1:0]    count;

  logic ai;
  logic bi;
  logic d;
  logic br_next;
  logic last_bit;
  logic accept;

  // Full-subtractor cell: half-subtractor on ai/bi plus the fed-back borrow.
  always_comb begin
    ai       = a_sh[0];
    bi       = b_sh[0];
    d        = ai ^ bi ^ borrow_reg;
    br_next  = (~ai & bi) | (~(ai ^ bi) & borrow_reg);
    last_bit = (count == CW'(WIDTH - 1));
    accept   = start_valid && (state == IDLE);
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output copies are loaded only on completion, so diff/borrow keep the last
  // finished result while the next operation shifts through res_sh/borrow_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      borrow_reg <= 1'b0;
      count      <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
    end else if (accept) begin
      a_sh       <= a;
      b_sh       <= b;
      borrow_reg <= 1'b0;
      count      <= '0;
    end else if (state == BUSY) begin
      a_sh       <= a_sh >> 1;
      b_sh       <= b_sh >> 1;
      res_sh     <= {d, res_sh[WIDTH-1:1]};
      borrow_reg <= br_next;
      count      <= count + CW'(1);
      if (last_bit) begin
        diff_q   <= {d, res_sh[WIDTH-1:1]};
        borrow_q <= br_next;
      end
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
